// File: rtl/wb_arb2.sv
// Two-master Wishbone B3 arbiter. Grants whole cyc-framed bus cycles, either
// round-robin or fixed priority, and forces err on a slave stall.

// Per-master response path: passes the slave response to the granted master
// and substitutes a lone err while the watchdog aborts its cycle.
module wb_arb2_rsp #(
    parameter int DW = 32
) (
    input  logic          sel,
    input  logic          abort,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic          s_rty,
    input  logic [DW-1:0] s_dat,
    output logic          ack,
    output logic          err,
    output logic          rty,
    output logic [DW-1:0] dat
);
    always_comb begin
        ack = sel & ~abort & s_ack;
        err = sel & (abort | s_err);
        rty = sel & ~abort & s_rty;
        dat = (sel & ~abort) ? s_dat : '0;
    end
endmodule

module wb_arb2 #(
    parameter int TIMEOUT    = 16,
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TW         = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    // master 0
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [TW-1:0]   m0_tgd_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    output logic [DW-1:0]   m0_dat_o,
    // master 1
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [TW-1:0]   m1_tgd_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [DW-1:0]   m1_dat_o,
    // shared slave bus
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [TW-1:0]   s_tgd_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    input  logic [DW-1:0]   s_dat_i,
    // status
    output logic [1:0]      gnt,
    output logic            busy,
    output logic            timeout
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_G0   = 3'd1;
    localparam logic [2:0] ST_G1   = 3'd2;
    localparam logic [2:0] ST_ERR0 = 3'd3;
    localparam logic [2:0] ST_ERR1 = 3'd4;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

    logic [1:0]                 m_cyc, m_stb, m_we;
    logic [1:0][AW-1:0]         m_adr;
    logic [1:0][DW/8-1:0]       m_sel;
    logic [1:0][DW-1:0]         m_dat;
    logic [1:0][TW-1:0]         m_tgd;
    logic [1:0]                 m_ack, m_err, m_rty;
    logic [1:0][DW-1:0]         m_rdat;

    logic [2:0]    state_q, state_d;
    logic          last_q, last_d;     // 0 = m0 held the bus last, 1 = m1
    logic [1:0]    gnt_q, gnt_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic own, in_g, in_err, stalled, expire;

    assign m_cyc = {m1_cyc_i, m0_cyc_i};
    assign m_stb = {m1_stb_i, m0_stb_i};
    assign m_we  = {m1_we_i,  m0_we_i};
    assign m_adr = {m1_adr_i, m0_adr_i};
    assign m_sel = {m1_sel_i, m0_sel_i};
    assign m_dat = {m1_dat_i, m0_dat_i};
    assign m_tgd = {m1_tgd_i, m0_tgd_i};

    always_comb begin
        own     = (state_q == ST_G1) || (state_q == ST_ERR1);
        in_g    = (state_q == ST_G0) || (state_q == ST_G1);
        in_err  = (state_q == ST_ERR0) || (state_q == ST_ERR1);
        stalled = in_g & m_cyc[own] & m_stb[own] & ~(s_ack_i | s_err_i | s_rty_i);
    end

    // Saturating stall counter; any response, stb low or leaving Gx clears it.
    always_comb begin
        wd_cnt_d = '0;
        if (stalled && (TIMEOUT > 0))
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + CW'(1);
        expire = (TIMEOUT > 0) && stalled && (wd_cnt_d == WD_MAX);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc[0] && (!m_cyc[1] || (FIXED_PRIO != 0) || last_q))
                    state_d = ST_G0;
                else if (m_cyc[1])
                    state_d = ST_G1;
            end
            ST_G0, ST_G1: begin
                // Release is checked first so it beats a same-cycle expiry.
                if (!m_cyc[own]) begin
                    last_d  = own;
                    state_d = m_cyc[~own] ? (own ? ST_G0 : ST_G1) : ST_IDLE;
                end else if (expire) begin
                    state_d = own ? ST_ERR1 : ST_ERR0;
                end
            end
            ST_ERR0: state_d = ST_G0;
            ST_ERR1: state_d = ST_G1;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_G0, ST_ERR0: gnt_d = 2'b01;
            ST_G1, ST_ERR1: gnt_d = 2'b10;
            default:        gnt_d = 2'b00;
        endcase
        timeout_d = (state_d == ST_ERR0) || (state_d == ST_ERR1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            timeout_q <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

    // Request path: cyc/stb only in Gx, so ERRx drops them and aborts the slave.
    always_comb begin
        s_cyc_o = in_g & m_cyc[own];
        s_stb_o = in_g & m_stb[own];
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_tgd_o = '0;
        if (busy) begin
            s_we_o  = m_we[own];
            s_adr_o = m_adr[own];
            s_sel_o = m_sel[own];
            s_dat_o = m_dat[own];
            s_tgd_o = m_tgd[own];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        wb_arb2_rsp #(.DW(DW)) u_rsp (
            .sel   (gnt_q[i]),
            .abort (in_err),
            .s_ack (s_ack_i),
            .s_err (s_err_i),
            .s_rty (s_rty_i),
            .s_dat (s_dat_i),
            .ack   (m_ack[i]),
            .err   (m_err[i]),
            .rty   (m_rty[i]),
            .dat   (m_rdat[i])
        );
    end

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_rty_o = m_rty[0];
    assign m0_dat_o = m_rdat[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_rty_o = m_rty[1];
    assign m1_dat_o = m_rdat[1];
endmodule
